// File: rtl/sound_latch_ctrl_pkg.sv
// Shared definitions for the 68K->Z80 sound command latch: NMI FSM states and counter sizing.
package sound_latch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } nmi_state_e;

    // Down-counter width covering both the pulse and gap lengths; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned gap);
        int unsigned m;
        m = (width > gap) ? width : gap;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sound_latch_ctrl_edge_det.sv
// Single-bit registered edge detector with asynchronous active-high reset.
module sound_latch_ctrl_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/sound_latch_ctrl.sv
// 68K->Z80 sound command latch: captures the command byte, pulses Z80 NMI per write,
// tracks pending/overrun state and is acknowledged by the end of a Z80 read.
module sound_latch_ctrl
    import sound_latch_ctrl_pkg::*;
#(
    parameter int unsigned NMI_WIDTH = 16,
    parameter int unsigned NMI_GAP   = 4,
    parameter int unsigned OVR_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sound_latch_cs,
    input  logic             m68k_rw,
    input  logic             m68k_lds_n,
    input  logic [7:0]       m68k_dout,
    input  logic             z80_latch_cs,
    input  logic             z80_rd_n,
    output logic [7:0]       z80_latch_dout,
    output logic             z80_nmi_n,
    output logic             latch_pending,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam int unsigned CntW = cnt_width(NMI_WIDTH, NMI_GAP);

    logic wr;
    logic rd;
    logic wr_rise;
    logic wr_fall;
    logic rd_rise;
    logic rd_fall;
    logic unused_edges;

    assign wr = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
    assign rd = z80_latch_cs & ~z80_rd_n;

    sound_latch_ctrl_edge_det u_wr_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (wr),
        .rise_o (wr_rise),
        .fall_o (wr_fall)
    );

    sound_latch_ctrl_edge_det u_rd_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (rd),
        .rise_o (rd_rise),
        .fall_o (rd_fall)
    );

    assign unused_edges = wr_fall ^ rd_rise;

    // Latch, pending and overrun state
    logic [7:0]       dout_d, dout_q;
    logic             pending_d, pending_q;
    logic [OVR_W-1:0] ovr_d, ovr_q;

    always_comb begin
        dout_d    = dout_q;
        pending_d = pending_q;
        ovr_d     = ovr_q;
        if (wr_rise) begin
            dout_d    = m68k_dout;
            pending_d = 1'b1;
            // A write landing on the read-ack cycle replaces an already consumed byte.
            if (pending_q && !rd_fall && (ovr_q != {OVR_W{1'b1}})) begin
                ovr_d = ovr_q + 1'b1;
            end
        end else if (rd_fall) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q    <= 8'h00;
            pending_q <= 1'b0;
            ovr_q     <= '0;
        end else begin
            dout_q    <= dout_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
        end
    end

    assign z80_latch_dout = dout_q;
    assign latch_pending  = pending_q;
    assign overrun_cnt    = ovr_q;

    // NMI FSM
    nmi_state_e      state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            retrig_d, retrig_q;
    logic            nmi_n_d, nmi_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            retrig_q <= 1'b0;
            nmi_n_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retrig_q <= retrig_d;
            nmi_n_q  <= nmi_n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retrig_d = retrig_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_rise) begin
                    state_d = S_PULSE;
                    cnt_d   = CntW'(NMI_WIDTH - 1);
                end
            end
            S_PULSE: begin
                if (wr_rise) begin
                    retrig_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = CntW'(NMI_GAP - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (wr_rise) begin
                    retrig_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    // A write arriving on the final gap cycle still earns its own pulse.
                    if (retrig_q || wr_rise) begin
                        state_d  = S_PULSE;
                        cnt_d    = CntW'(NMI_WIDTH - 1);
                        retrig_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                retrig_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        nmi_n_d = (state_d != S_PULSE);
    end

    assign z80_nmi_n = nmi_n_q;

endmodule

// File: tb/tb_sound_latch_ctrl.sv
// Directed self-checking bench for sound_latch_ctrl with an NMI pulse/gap monitor.
module tb_sound_latch_ctrl;

    logic       clk;
    logic       reset;
    logic       sound_latch_cs;
    logic       m68k_rw;
    logic       m68k_lds_n;
    logic [7:0] m68k_dout;
    logic       z80_latch_cs;
    logic       z80_rd_n;
    logic [7:0] z80_latch_dout;
    logic       z80_nmi_n;
    logic       latch_pending;
    logic [3:0] overrun_cnt;

    int unsigned errors;
    int unsigned checks;

    sound_latch_ctrl #(
        .NMI_WIDTH (16),
        .NMI_GAP   (4),
        .OVR_W     (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sound_latch_cs (sound_latch_cs),
        .m68k_rw        (m68k_rw),
        .m68k_lds_n     (m68k_lds_n),
        .m68k_dout      (m68k_dout),
        .z80_latch_cs   (z80_latch_cs),
        .z80_rd_n       (z80_rd_n),
        .z80_latch_dout (z80_latch_dout),
        .z80_nmi_n      (z80_nmi_n),
        .latch_pending  (latch_pending),
        .overrun_cnt    (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NMI monitor, sampled on the falling edge
    int unsigned pulses   = 0;
    int unsigned low_run  = 0;
    int unsigned high_run = 0;
    int unsigned last_low = 0;
    int unsigned last_gap = 0;
    logic        seen     = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            low_run  <= 0;
            high_run <= 0;
            seen     <= 1'b0;
        end else if (!z80_nmi_n) begin
            if (low_run == 0) begin
                pulses <= pulses + 1;
                if (seen) last_gap <= high_run;
            end
            low_run  <= low_run + 1;
            high_run <= 0;
        end else begin
            if (low_run != 0) begin
                last_low <= low_run;
                seen     <= 1'b1;
            end
            low_run  <= 0;
            high_run <= high_run + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_on(input logic [7:0] b);
        sound_latch_cs = 1'b1;
        m68k_rw        = 1'b0;
        m68k_lds_n     = 1'b0;
        m68k_dout      = b;
    endtask

    task automatic wr_off();
        sound_latch_cs = 1'b0;
        m68k_rw        = 1'b1;
        m68k_lds_n     = 1'b1;
    endtask

    task automatic rd_set(input logic on);
        z80_latch_cs = on;
        z80_rd_n     = ~on;
    endtask

    int unsigned p0;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        wr_off();
        m68k_dout = 8'h00;
        rd_set(1'b0);
        step(2);
        reset = 1'b0;
        step(2);
        check_eq("idle_nmi", 32'(z80_nmi_n), 32'd1);

        // 1: reset in the middle of a pulse
        wr_on(8'hA5);
        step(1);
        wr_off();
        step(3);
        check_eq("t1_nmi_low", 32'(z80_nmi_n), 32'd0);
        check_eq("t1_pend_pre", 32'(latch_pending), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("t1_rst_nmi", 32'(z80_nmi_n), 32'd1);
        check_eq("t1_rst_pend", 32'(latch_pending), 32'd0);
        check_eq("t1_rst_dout", 32'(z80_latch_dout), 32'h00);
        check_eq("t1_rst_ovr", 32'(overrun_cnt), 32'd0);
        step(2);
        reset = 1'b0;
        step(3);
        check_eq("t1_after_nmi", 32'(z80_nmi_n), 32'd1);

        // 2: write 0x5A held three cycles
        p0 = pulses;
        wr_on(8'h5A);
        step(1);
        check_eq("t2_dout", 32'(z80_latch_dout), 32'h5A);
        check_eq("t2_pend", 32'(latch_pending), 32'd1);
        m68k_dout = 8'h77;
        step(2);
        wr_off();
        check_eq("t2_hold", 32'(z80_latch_dout), 32'h5A);
        step(30);
        check_eq("t2_npulses", pulses - p0, 32'd1);
        check_eq("t2_width", last_low, 32'd16);

        // 3: four-cycle Z80 read
        rd_set(1'b1);
        step(4);
        check_eq("t3_pend_mid", 32'(latch_pending), 32'd1);
        rd_set(1'b0);
        step(1);
        check_eq("t3_pend_ack", 32'(latch_pending), 32'd0);
        check_eq("t3_dout", 32'(z80_latch_dout), 32'h5A);

        // 4: second write during the first pulse
        p0 = pulses;
        wr_on(8'h11);
        step(1);
        wr_off();
        step(4);
        wr_on(8'h22);
        step(1);
        wr_off();
        check_eq("t4_dout", 32'(z80_latch_dout), 32'h22);
        check_eq("t4_ovr", 32'(overrun_cnt), 32'd1);
        step(60);
        check_eq("t4_npulses", pulses - p0, 32'd2);
        check_eq("t4_gap", last_gap, 32'd4);
        check_eq("t4_width", last_low, 32'd16);

        // 5: write rise and read fall on the same edge
        rd_set(1'b1);
        step(2);
        rd_set(1'b0);
        wr_on(8'h33);
        step(1);
        wr_off();
        check_eq("t5_pend", 32'(latch_pending), 32'd1);
        check_eq("t5_ovr", 32'(overrun_cnt), 32'd1);
        check_eq("t5_dout", 32'(z80_latch_dout), 32'h33);
        step(40);

        // 6: seventeen unread writes saturate the overrun counter
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(2);
        p0 = pulses;
        for (int k = 1; k <= 17; k++) begin
            wr_on(8'(k * 3));
            step(1);
            wr_off();
            if (k == 2)  check_eq("t6_ovr_k2", 32'(overrun_cnt), 32'd1);
            if (k == 16) check_eq("t6_ovr_k16", 32'(overrun_cnt), 32'd15);
            step(40);
        end
        check_eq("t6_ovr_sat", 32'(overrun_cnt), 32'd15);
        check_eq("t6_npulses", pulses - p0, 32'd17);
        check_eq("t6_dout", 32'(z80_latch_dout), 32'd51);
        check_eq("t6_pend", 32'(latch_pending), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
